// File: rtl/fetch_unit_if.sv
// Instruction memory read port: request side (memread/address) and the
// registered read data returned one cycle after a sampled memread.
interface fetch_unit_if;
  logic        memread;
  logic [31:0] address;
  logic [31:0] readdata;

  modport master (output memread, output address, input readdata);
  modport slave  (input memread, input address, output readdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch requester: owns the PC, issues one word read per cycle,
// captures returned words into the IF/ID register, and handles stall,
// redirect and out-of-range/misaligned fetch faults.
//
// state   | meaning
// S_BOOT  | one bubble cycle after reset, no read issued
// S_RUN   | normal fetching, one request per non-stalled cycle
// S_FAULT | bad PC reached; fetching stopped until reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 256,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_target,
  fetch_unit_if.master       imem,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc_plus4,
  output logic               if_id_valid,
  output logic               fetch_fault,
  output logic [CNT_W-1:0]   fetch_count
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_FAULT} state_t;

  localparam logic [31:0] LAST_ADDR = 32'(4 * DEPTH - 4);

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        req_valid;
  logic        pc_ok;
  logic        issue;

  assign pc_ok        = (pc[1:0] == 2'b00) && (pc <= LAST_ADDR);
  assign issue        = (state == S_RUN) && !stall && !redirect && pc_ok;
  assign imem.address = pc;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_BOOT;
    else       state <= state_nxt;
  end

  // Next-state and read-enable decode.
  always_comb begin
    state_nxt    = state;
    imem.memread = 1'b0;
    case (state)
      S_BOOT:  state_nxt = S_RUN;
      S_RUN: begin
        imem.memread = issue;
        if (!redirect && !stall && !pc_ok) state_nxt = S_FAULT;
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_BOOT;
    endcase
  end

  // PC, in-flight request tracking and IF/ID register updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      req_valid      <= 1'b0;
      req_pc         <= 32'h0;
      if_id_instr    <= 32'h0;
      if_id_pc       <= 32'h0;
      if_id_pc_plus4 <= 32'h4;
      if_id_valid    <= 1'b0;
      fetch_fault    <= 1'b0;
      fetch_count    <= '0;
    end else begin
      case (state)
        S_BOOT: begin
          if (redirect) pc <= redirect_target;
        end
        S_RUN: begin
          if (redirect) begin
            // Drop whatever is in flight; IF/ID payload is left as-is.
            pc          <= redirect_target;
            req_valid   <= 1'b0;
            if_id_valid <= 1'b0;
          end else if (!stall) begin
            if (req_valid) begin
              if_id_instr    <= imem.readdata;
              if_id_pc       <= req_pc;
              if_id_pc_plus4 <= req_pc + 32'd4;
              if_id_valid    <= 1'b1;
              fetch_count    <= fetch_count + 1'b1;
            end else begin
              if_id_valid <= 1'b0;
            end
            if (pc_ok) begin
              req_pc    <= pc;
              pc        <= pc + 32'd4;
              req_valid <= 1'b1;
            end else begin
              req_valid   <= 1'b0;
              fetch_fault <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          if (!stall) if_id_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency instruction memory
// model where word i holds 32'h1000_0000 + i.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;
  logic        if_id_valid, fetch_fault;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(256), .CNT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem            (imem.master),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_valid     (if_id_valid),
    .fetch_fault     (fetch_fault),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  // memory model: registered read data, held while memread is low
  initial imem.readdata = 32'h0;
  always @(posedge clk)
    if (imem.memread) imem.readdata <= 32'h1000_0000 + (imem.address >> 2);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_valid"}, 32'(if_id_valid), 32'h0);
    check_val({tag, "_instr"}, if_id_instr, 32'h0);
    check_val({tag, "_pc"}, if_id_pc, 32'h0);
    check_val({tag, "_pc4"}, if_id_pc_plus4, 32'h4);
    check_val({tag, "_fault"}, 32'(fetch_fault), 32'h0);
    check_val({tag, "_count"}, 32'(fetch_count), 32'h0);
  endtask

  task automatic check_deliver(input string tag, input logic [31:0] pc);
    check_val({tag, "_valid"}, 32'(if_id_valid), 32'h1);
    check_val({tag, "_pc"}, if_id_pc, pc);
    check_val({tag, "_pc4"}, if_id_pc_plus4, pc + 32'd4);
    check_val({tag, "_instr"}, if_id_instr, 32'h1000_0000 + (pc >> 2));
  endtask

  // Two reset edges, then release; returns in the boot cycle.
  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    #1;
    check_val("boot_memread", 32'(imem.memread), 32'h0);
  endtask

  initial begin
    // sequential fetch and stall
    do_reset();
    tick();
    check_val("run_memread", 32'(imem.memread), 32'h1);
    check_val("addr0", imem.address, 32'h0);
    tick();
    check_val("addr4", imem.address, 32'h4);
    check_val("first_valid", 32'(if_id_valid), 32'h0);
    tick();
    check_deliver("d0", 32'h0);
    check_val("addr8", imem.address, 32'h8);
    tick();
    check_deliver("d4", 32'h4);
    check_val("addr12", imem.address, 32'hC);
    tick();
    check_deliver("d8", 32'h8);
    stall = 1'b1;
    #1;
    check_val("stall_memread", 32'(imem.memread), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_deliver("stall_hold", 32'h8);
      check_val("stall_addr", imem.address, 32'h10);
      check_val("stall_mr", 32'(imem.memread), 32'h0);
    end
    stall = 1'b0;
    tick();
    check_deliver("d12", 32'hC);
    check_val("count4", 32'(fetch_count), 32'h4);

    // redirect while IF/ID holds pc=4
    do_reset();
    tick(); tick(); tick(); tick();
    check_deliver("pre_redir", 32'h4);
    redirect = 1'b1; redirect_target = 32'h40;
    #1;
    check_val("redir_mr", 32'(imem.memread), 32'h0);
    tick();
    redirect = 1'b0;
    check_val("redir_valid", 32'(if_id_valid), 32'h0);
    check_val("redir_addr", imem.address, 32'h40);
    check_val("redir_hold_pc", if_id_pc, 32'h4);
    tick();
    check_val("redir_bubble", 32'(if_id_valid), 32'h0);
    tick();
    check_deliver("d40", 32'h40);
    tick();
    check_deliver("d44", 32'h44);

    // redirect during stall
    stall = 1'b1; redirect = 1'b1; redirect_target = 32'h20;
    tick();
    stall = 1'b0; redirect = 1'b0;
    check_val("sr_valid", 32'(if_id_valid), 32'h0);
    check_val("sr_addr", imem.address, 32'h20);
    tick();
    tick();
    check_deliver("d20", 32'h20);

    // fault at end of memory
    redirect = 1'b1; redirect_target = 32'h3FC;
    tick();
    redirect = 1'b0;
    tick();
    check_val("last_issue_addr", imem.address, 32'h400);
    tick();
    check_deliver("d3fc", 32'h3FC);
    check_val("fault_set", 32'(fetch_fault), 32'h1);
    check_val("fault_mr", 32'(imem.memread), 32'h0);
    redirect = 1'b1; redirect_target = 32'h0;
    tick();
    redirect = 1'b0;
    check_val("fault_valid", 32'(if_id_valid), 32'h0);
    check_val("fault_sticky", 32'(fetch_fault), 32'h1);
    check_val("fault_ign_redir", imem.address, 32'h400);
    tick();
    check_val("fault_mr2", 32'(imem.memread), 32'h0);
    do_reset();

    // reset mid-stream while valid and stalled
    tick(); tick(); tick();
    check_deliver("mid_d0", 32'h0);
    stall = 1'b1; reset = 1'b1;
    tick();
    check_reset_vals("mid_rst");
    check_val("mid_rst_addr", imem.address, 32'h0);
    reset = 1'b0; stall = 1'b0;
    #1;
    check_val("mid_boot_mr", 32'(imem.memread), 32'h0);
    tick();
    check_val("mid_run_mr", 32'(imem.memread), 32'h1);
    check_val("mid_run_addr", imem.address, 32'h0);
    tick(); tick();
    check_deliver("mid_d0b", 32'h0);
    check_val("mid_count", 32'(fetch_count), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch requester that drives the instruction memory bank's read port (memread/address in, registered readdata out, one-cycle latency). It owns the PC and issues one word-aligned byte address per cycle. It captures the returned word into the IF/ID pipeline register and handles stall, branch/jump redirect, and out-of-range fetch faults. It sits between the PC-select logic and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset
DEPTH, 256, instruction memory depth in 32-bit words; legal addresses are 0 .. 4*DEPTH-4
CNT_W, 16, width of fetch_count

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit request to hold IF/ID and the PC
redirect  input  1  taken branch/jump from a later stage
redirect_target  input  32  byte address of the new fetch stream
imem_memread  output  1  read enable to instruction memory (combinational)
imem_address  output  32  byte address to instruction memory (= pc)
imem_readdata  input  32  memory data; valid the cycle after a sampled memread, held while memread=0
if_id_instr  output  32  fetched instruction
if_id_pc  output  32  byte address of if_id_instr
if_id_pc_plus4  output  32  if_id_pc + 4
if_id_valid  output  1  IF/ID contents are a real instruction
fetch_fault  output  1  sticky: misaligned or out-of-range PC reached
fetch_count  output  CNT_W  number of instructions delivered to IF/ID

Behaviour:
- Internal state: pc, req_valid, req_pc, FSM {S_BOOT, S_RUN, S_FAULT}.
- Reset has highest priority and a synchronous effect:
  - pc=RESET_PC, req_valid=0, req_pc=0.
  - if_id_instr=0, if_id_pc=0, if_id_pc_plus4=4, if_id_valid=0.
  - fetch_fault=0, fetch_count=0, state=S_BOOT.
- S_BOOT: one bubble cycle with imem_memread=0, then go to S_RUN unconditionally. A redirect in S_BOOT loads pc and is still honoured.
- S_RUN:
  - issue = !stall && !redirect && pc_ok, where pc_ok = (pc[1:0]==0) && (pc <= 4*DEPTH-4).
  - imem_memread = issue; imem_address = pc at all times.
- Edge update in S_RUN, by priority:
  - redirect (wins over stall):
    - pc<=redirect_target, req_valid<=0, if_id_valid<=0; if_id_instr/pc held.
    - The in-flight response is discarded; fetch_count is unchanged.
  - stall:
    - pc, req_valid, req_pc and all IF/ID outputs hold. No memread is issued.
    - imem_readdata therefore keeps the pending word, so no skid buffer is needed.
  - otherwise:
    - If req_valid: if_id_instr<=imem_readdata, if_id_pc<=req_pc, if_id_pc_plus4<=req_pc+4, if_id_valid<=1, fetch_count+=1 (wraps modulo 2^CNT_W).
    - Else: if_id_valid<=0.
    - If issue: req_pc<=pc, pc<=pc+4, req_valid<=1.
    - Else (pc not ok): req_valid<=0, fetch_fault<=1, state<=S_FAULT.
- S_FAULT:
  - imem_memread=0 permanently; fetch_fault stays 1.
  - The last valid request, if any, was already delivered on the transition edge; afterwards if_id_valid<=0 on every non-stalled edge.
  - redirect and stall are ignored except that stall holds IF/ID. Exit only by reset.
- Latency: an address issued in cycle t appears in IF/ID at the edge ending cycle t+1 if no stall or redirect intervenes. Steady-state throughput is 1 instruction/cycle.
- Arithmetic: all PC math is 32-bit unsigned. pc+4 at 32'hFFFF_FFFC wraps to 0, but the range check faults before that point.
- A redirect to a misaligned or out-of-range target is accepted into pc; the fault is raised on the following non-stalled, non-redirect cycle.

Test Plan:
- Sequential fetch: bench memory model where word i = 32'h1000_0000+i, RESET_PC=0, reset for 2 cycles then release.
  - Required: memread=0 in the boot cycle; addresses 0,4,8,12 on consecutive cycles.
  - Required: if_id_instr 10000000,10000001,... with if_id_pc 0,4,8; fetch_count=4 after 4 deliveries.
- Stall mid-stream: assert stall for 3 cycles while IF/ID holds pc=8.
  - Required: IF/ID frozen at 8/0x10000002, memread=0, address stays 16.
  - Required: after release, next delivered pc=12 (0x10000003), with no duplicate and no skip.
- Redirect: redirect=1, target=0x40 while IF/ID holds pc=4.
  - Required: next edge if_id_valid=0 and pc=0x40; the word from address 8 is never delivered.
  - Required: following deliveries are 0x40 (0x10000010), 0x44, ...
- Redirect during stall: stall=1 and redirect=1, target=0x20.
  - Required: the flush happens (valid=0, pc=0x20) despite the stall.
- Fault: redirect target=0x3FC with DEPTH=256.
  - Required: instruction at 0x3FC is delivered, then fetch_fault=1, memread stays 0, and if_id_valid=0 thereafter.
  - Required: a subsequent redirect has no effect; reset clears everything.
- Reset mid-stream: assert reset while valid=1 and stall=1.
  - Required: all outputs return to reset values on that edge, then the boot bubble, then a fetch from RESET_PC.
